// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types and constants for the pipeline control slice.
//   sb_entry_t   : one scoreboard slot {valid, rd, reg_write, is_load}
//   pipe_state_e : halt-drain FSM states (RUN, DRAIN, HALTED)
//   FWD_REGFILE  : forwarding select value meaning "read the register file"
//   REG_ZERO     : register number of the hard-wired zero register
// SB_RD_W is the stored register-number width; REG_W of the users must not exceed it.
package mips_pipe_pkg;

  localparam int unsigned SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  localparam int unsigned        FWD_REGFILE = 0;
  localparam logic [SB_RD_W-1:0] REG_ZERO    = '0;

endpackage

// File: rtl/mips_scoreboard.sv
// mips_scoreboard: DEPTH-slot destination-register shift register (slot 1 = EX,
// slot DEPTH = WB) with per-slot source-match vectors.
// Ports:
//   clk, rst_b            : clock, synchronous active-low reset
//   advance               : shift the slots (pipe not frozen)
//   new_valid/new_rd/new_reg_write/new_is_load : entry loaded into slot 1
//   rs_num, rt_num        : ID source registers
//   uses_rs, uses_rt      : source really read by a valid ID instruction
//   match_rs, match_rt    : bit j set when slot j produces that source
//   slot1_load            : slot 1 holds a load
//   drain_done            : slots 1..DEPTH-1 empty (scoreboard empty after next shift)
module mips_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             advance,
  input  logic             new_valid,
  input  logic [REG_W-1:0] new_rd,
  input  logic             new_reg_write,
  input  logic             new_is_load,
  input  logic [REG_W-1:0] rs_num,
  input  logic [REG_W-1:0] rt_num,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic [DEPTH:1]   match_rs,
  output logic [DEPTH:1]   match_rt,
  output logic             slot1_load,
  output logic             drain_done
);

  sb_entry_t          slots [1:DEPTH];
  sb_entry_t          new_entry;
  logic [SB_RD_W-1:0] rs_ext;
  logic [SB_RD_W-1:0] rt_ext;

  assign rs_ext = SB_RD_W'(rs_num);
  assign rt_ext = SB_RD_W'(rt_num);

  // Bubbles are stored as all-zero entries so stale fields never match.
  always_comb begin
    new_entry = '0;
    if (new_valid) begin
      new_entry.valid     = 1'b1;
      new_entry.rd        = SB_RD_W'(new_rd);
      new_entry.reg_write = new_reg_write;
      new_entry.is_load   = new_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int unsigned k = 1; k <= DEPTH; k++) slots[k] <= '0;
    end else if (advance) begin
      slots[1] <= new_entry;
      for (int unsigned k = 2; k <= DEPTH; k++) slots[k] <= slots[k-1];
    end
  end

  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int unsigned j = 1; j <= DEPTH; j++) begin
      if (slots[j].valid && slots[j].reg_write && (slots[j].rd != REG_ZERO)) begin
        match_rs[j] = uses_rs && (slots[j].rd == rs_ext);
        match_rt[j] = uses_rt && (slots[j].rd == rt_ext);
      end
    end
  end

  assign slot1_load = slots[1].is_load;

  // The WB slot retires on the next shift, so only slots 1..DEPTH-1 matter.
  always_comb begin
    drain_done = 1'b1;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      if (slots[j].valid) drain_done = 1'b0;
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: pipeline control unit. Generates PC / IF-ID enables, IF-ID
// flush and ID-EX bubble, registered forwarding selects, and runs the
// RUN -> DRAIN -> HALTED halt-drain FSM.
// Ports:
//   clk, rst_b                        : clock, synchronous active-low reset
//   cache_done                        : 0 freezes the whole pipe
//   id_valid, id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
//   id_rd_num, id_reg_write, id_is_load, id_is_halt : ID instruction
//   redirect                          : taken branch/jump resolved in EX
//   pc_en, if_id_en, if_id_flush, id_ex_bubble      : stage controls (combinational)
//   fwd_a_sel, fwd_b_sel              : 0 = regfile, k = result of slot k
//   halted                            : sticky halt
//   stall_cycles, flush_count, freeze_cycles        : perf counters
// Build option: MIPS_PIPE_PERF_EN builds saturating perf counters; otherwise
// the counter ports are constant 0.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     cache_done,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_rs_num,
  input  logic [REG_W-1:0]         id_rt_num,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic [REG_W-1:0]         id_rd_num,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     id_is_halt,
  input  logic                     redirect,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     if_id_flush,
  output logic                     id_ex_bubble,
  output logic [$clog2(DEPTH)-1:0] fwd_a_sel,
  output logic [$clog2(DEPTH)-1:0] fwd_b_sel,
  output logic                     halted,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_count,
  output logic [CNT_W-1:0]         freeze_cycles
);

  localparam int unsigned SEL_W = $clog2(DEPTH);

  pipe_state_e      state;
  pipe_state_e      state_nxt;
  logic [DEPTH:1]   match_rs;
  logic [DEPTH:1]   match_rt;
  logic             slot1_load;
  logic             drain_done;
  logic             load_use;
  logic             take_id;
  logic [SEL_W-1:0] sel_a_nxt;
  logic [SEL_W-1:0] sel_b_nxt;

  mips_scoreboard #(
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_b         (rst_b),
    .advance       (cache_done),
    .new_valid     (take_id && id_valid),
    .new_rd        (id_rd_num),
    .new_reg_write (id_reg_write),
    .new_is_load   (id_is_load),
    .rs_num        (id_rs_num),
    .rt_num        (id_rt_num),
    .uses_rs       (id_valid && id_uses_rs),
    .uses_rt       (id_valid && id_uses_rt),
    .match_rs      (match_rs),
    .match_rt      (match_rt),
    .slot1_load    (slot1_load),
    .drain_done    (drain_done)
  );

  assign load_use = (match_rs[1] || match_rt[1]) && slot1_load;

  // Scan oldest to youngest so the youngest producer wins; a WB-slot match
  // maps to the regfile because the write lands at the same edge.
  always_comb begin
    sel_a_nxt = SEL_W'(FWD_REGFILE);
    sel_b_nxt = SEL_W'(FWD_REGFILE);
    for (int unsigned j = DEPTH; j >= 1; j--) begin
      if (match_rs[j]) sel_a_nxt = (j == DEPTH) ? SEL_W'(FWD_REGFILE) : SEL_W'(j);
      if (match_rt[j]) sel_b_nxt = (j == DEPTH) ? SEL_W'(FWD_REGFILE) : SEL_W'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (take_id && id_valid && id_is_halt) state_nxt = DRAIN;
      DRAIN:   if (cache_done && drain_done) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Redirect outranks the load-use stall and a halt in ID (both wrong path).
  // In DRAIN, IF/ID keeps loading NOPs and ID/EX gets bubbles.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    take_id      = 1'b0;
    halted       = (state == HALTED);
    if (cache_done) begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            take_id  = 1'b1;
          end
        end
        DRAIN: begin
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      fwd_a_sel <= SEL_W'(FWD_REGFILE);
      fwd_b_sel <= SEL_W'(FWD_REGFILE);
    end else if (cache_done) begin
      fwd_a_sel <= take_id ? sel_a_nxt : SEL_W'(FWD_REGFILE);
      fwd_b_sel <= take_id ? sel_b_nxt : SEL_W'(FWD_REGFILE);
    end
  end

`ifdef MIPS_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] freeze_q;
  logic             stall_evt;
  logic             flush_evt;
  logic             freeze_evt;

  // A bubble without a flush only happens on a load-use stall.
  assign stall_evt  = id_ex_bubble && !if_id_flush;
  assign flush_evt  = if_id_flush && (state == RUN);
  assign freeze_evt = !cache_done && (state != HALTED);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1))   stall_q  <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1))   flush_q  <= flush_q + CNT_W'(1);
      if (freeze_evt && (freeze_q != '1)) freeze_q <= freeze_q + CNT_W'(1);
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign freeze_cycles = freeze_q;
`else
  assign stall_cycles  = '0;
  assign flush_count   = '0;
  assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: directed vector table, hand-written reset/halt sequences
// and a randomized run against a behavioural model of mips_pipe_ctrl.
module tb_mips_pipe_ctrl;

  localparam int D  = 3;
  localparam int RW = 5;
  localparam int CW = 32;
`ifdef MIPS_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_b, cache_done, id_valid, id_uses_rs, id_uses_rt;
  logic [RW-1:0] id_rs_num, id_rt_num, id_rd_num;
  logic          id_reg_write, id_is_load, id_is_halt, redirect;
  logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles, flush_count, freeze_cycles;

  mips_pipe_ctrl #(.DEPTH(D), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .cache_done(cache_done), .id_valid(id_valid),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_rd_num(id_rd_num), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .redirect(redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit cd, redir, v; int rs; bit urs; int rt; bit urt; int rd; bit rw, ld, halt;
    bit e_pc, e_ifid, e_fl, e_bub; int e_fa, e_fb; bit e_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cd, bit redir, bit v, int rs, bit urs, int rt, bit urt,
                              int rd, bit rw, bit ld, bit halt, bit pc, bit ifid, bit fl,
                              bit bub, int fa, int fb, bit hl);
    vec_t r;
    r.cd = cd; r.redir = redir; r.v = v; r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt;
    r.rd = rd; r.rw = rw; r.ld = ld; r.halt = halt;
    r.e_pc = pc; r.e_ifid = ifid; r.e_fl = fl; r.e_bub = bub;
    r.e_fa = fa; r.e_fb = fb; r.e_halted = hl;
    return r;
  endfunction

  task automatic drive(input bit cd, input bit redir, input bit v, input int rs, input bit urs,
                       input int rt, input bit urt, input int rd, input bit rw, input bit ld,
                       input bit halt);
    cache_done = cd; redirect = redir; id_valid = v;
    id_rs_num = RW'(rs); id_uses_rs = urs; id_rt_num = RW'(rt); id_uses_rt = urt;
    id_rd_num = RW'(rd); id_reg_write = rw; id_is_load = ld; id_is_halt = halt;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { bit v; int rd; bit rw; bit ld; } inst_t;
  inst_t  m_pipe [1:D];
  int     m_fa, m_fb, m_mode;       // mode: 0 running, 1 draining, 2 halted
  longint m_stall, m_flush, m_freeze;

  function automatic void m_reset();
    for (int k = 1; k <= D; k++) m_pipe[k] = '{0, 0, 0, 0};
    m_fa = 0; m_fb = 0; m_mode = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
  endfunction

  function automatic bit m_writes(int k, int src);
    return m_pipe[k].v && m_pipe[k].rw && (m_pipe[k].rd == src) && (src != 0);
  endfunction

  function automatic bit m_load_use();
    return id_valid && m_pipe[1].ld &&
           ((id_uses_rs && m_writes(1, int'(id_rs_num))) ||
            (id_uses_rt && m_writes(1, int'(id_rt_num))));
  endfunction

  // Nearest older producer that has not reached WB; otherwise read the regfile.
  function automatic int m_fwd(bit uses, int src);
    if (!id_valid || !uses) return 0;
    for (int k = 1; k < D; k++) if (m_writes(k, src)) return k;
    return 0;
  endfunction

  function automatic void m_edge();
    bit acc, empty;
    int fa, fb;
    if (!rst_b) begin m_reset(); return; end
    if (!cache_done) begin
      if (m_mode != 2) m_freeze++;
      return;
    end
    acc = (m_mode == 0) && !redirect && !m_load_use();
    if (m_mode == 0 && redirect) m_flush++;
    if (m_mode == 0 && !redirect && m_load_use()) m_stall++;
    fa = acc ? m_fwd(id_uses_rs, int'(id_rs_num)) : 0;
    fb = acc ? m_fwd(id_uses_rt, int'(id_rt_num)) : 0;
    for (int k = D; k >= 2; k--) m_pipe[k] = m_pipe[k-1];
    if (acc && id_valid) m_pipe[1] = '{1, int'(id_rd_num), id_reg_write, id_is_load};
    else                 m_pipe[1] = '{0, 0, 0, 0};
    m_fa = fa; m_fb = fb;
    if (m_mode == 0 && acc && id_valid && id_is_halt) m_mode = 1;
    else if (m_mode == 1) begin
      empty = 1'b1;
      for (int k = 1; k <= D; k++) if (m_pipe[k].v) empty = 1'b0;
      if (empty) m_mode = 2;
    end
  endfunction

  function automatic void m_check();
    bit pc, ifid, fl, bub;
    pc = 0; ifid = 0; fl = 0; bub = 0;
    if (cache_done) begin
      if (m_mode == 0) begin
        if (redirect)          begin pc = 1; ifid = 1; fl = 1; bub = 1; end
        else if (m_load_use()) begin bub = 1; end
        else                   begin pc = 1; ifid = 1; end
      end else if (m_mode == 1) begin
        ifid = 1; fl = 1; bub = 1;
      end
    end
    chk("rnd_pc_en", pc_en, pc);
    chk("rnd_if_id_en", if_id_en, ifid);
    chk("rnd_if_id_flush", if_id_flush, fl);
    chk("rnd_id_ex_bubble", id_ex_bubble, bub);
    chk("rnd_fwd_a_sel", fwd_a_sel, m_fa);
    chk("rnd_fwd_b_sel", fwd_b_sel, m_fb);
    chk("rnd_halted", halted, m_mode == 2);
    chk("rnd_stall_cycles", stall_cycles, PERF ? m_stall : 0);
    chk("rnd_flush_count", flush_count, PERF ? m_flush : 0);
    chk("rnd_freeze_cycles", freeze_cycles, PERF ? m_freeze : 0);
  endfunction

  task automatic do_reset();
    rst_b = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  initial begin
    int halted_run;
    // (cd,redir,v,rs,urs,rt,urt,rd,rw,ld,halt, pc,ifid,flush,bubble,fa,fb,halted)
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 1,1,0,0, 0,0,0)); // idle after reset
    vecs.push_back(mk(1,0,1, 0,0, 0,0, 8,1,1,0, 1,1,0,0, 0,0,0)); // lw r8
    vecs.push_back(mk(1,0,1, 8,1, 0,0, 9,1,0,0, 0,0,0,1, 0,0,0)); // uses r8: stall
    vecs.push_back(mk(1,0,1, 8,1, 0,0, 9,1,0,0, 1,1,0,0, 0,0,0)); // advances
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 1,1,0,0, 2,0,0)); // select 2 in EX
    vecs.push_back(mk(1,0,1, 1,1, 0,0, 3,1,0,0, 1,1,0,0, 0,0,0)); // add r3
    vecs.push_back(mk(1,0,1, 3,1, 9,1, 4,1,0,0, 1,1,0,0, 0,0,0)); // r3 gap0, r9 in WB
    vecs.push_back(mk(1,0,1, 3,1, 4,1, 5,1,0,0, 1,1,0,0, 1,0,0)); // r3 gap1, r4 gap0
    vecs.push_back(mk(1,0,1, 3,1, 0,1, 6,1,0,0, 1,1,0,0, 2,1,0)); // r3 gap2, r0
    vecs.push_back(mk(1,0,1, 0,0, 0,0, 0,1,1,0, 1,1,0,0, 0,0,0)); // lw r0
    vecs.push_back(mk(1,0,1, 0,1, 6,1, 7,1,0,0, 1,1,0,0, 0,0,0)); // r0 no stall, r6 gap1
    vecs.push_back(mk(1,0,1, 0,0, 0,0,10,1,1,0, 1,1,0,0, 0,2,0)); // lw r10
    vecs.push_back(mk(1,1,1,10,1, 0,0,11,1,0,0, 1,1,1,1, 0,0,0)); // redirect beats stall
    vecs.push_back(mk(1,0,1,10,1, 0,0,14,1,0,0, 1,1,0,0, 0,0,0)); // r10 from slot 2
    vecs.push_back(mk(1,0,1,14,1, 0,0,12,1,1,0, 1,1,0,0, 2,0,0)); // lw r12, r14 gap0
    for (int i = 0; i < 5; i++)                                   // freeze, dependent in ID
      vecs.push_back(mk(0,(i==2),1,12,1, 0,0,13,1,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,1,12,1, 0,0,13,1,0,0, 0,0,0,1, 1,0,0)); // stall after freeze
    vecs.push_back(mk(1,0,1,12,1, 0,0,13,1,0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 1,1,0,0, 2,0,0));
    vecs.push_back(mk(1,0,1, 0,0, 0,0,15,1,0,0, 1,1,0,0, 0,0,0)); // older #1
    vecs.push_back(mk(1,0,1, 0,0, 0,0,16,1,0,0, 1,1,0,0, 0,0,0)); // older #2
    vecs.push_back(mk(1,0,1, 0,0, 0,0, 0,0,0,1, 1,1,0,0, 0,0,0)); // halt leaves ID
    vecs.push_back(mk(1,0,1,16,1,15,1,17,1,0,0, 0,1,1,1, 0,0,0)); // drain adv 1
    vecs.push_back(mk(0,0,1,16,1,15,1,17,1,0,0, 0,0,0,0, 0,0,0)); // freeze in drain
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0,1,1,1, 0,0,0)); // drain adv 2
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0,1,1,1, 0,0,0)); // drain adv 3
    vecs.push_back(mk(1,1,1, 0,0, 0,0, 0,0,0,0, 0,0,0,0, 0,0,1)); // halted
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0, 0,0,1));

    do_reset();
    @(negedge clk);
    chk("reset_halted", halted, 0);
    chk("reset_fwd_a", fwd_a_sel, 0);
    chk("reset_fwd_b", fwd_b_sel, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_flush_count", flush_count, 0);
    chk("reset_freeze_cycles", freeze_cycles, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].cd, vecs[i].redir, vecs[i].v, vecs[i].rs, vecs[i].urs, vecs[i].rt,
            vecs[i].urt, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].halt);
      @(negedge clk);
      chk($sformatf("vec%0d_pc_en", i), pc_en, vecs[i].e_pc);
      chk($sformatf("vec%0d_if_id_en", i), if_id_en, vecs[i].e_ifid);
      chk($sformatf("vec%0d_if_id_flush", i), if_id_flush, vecs[i].e_fl);
      chk($sformatf("vec%0d_id_ex_bubble", i), id_ex_bubble, vecs[i].e_bub);
      chk($sformatf("vec%0d_fwd_a_sel", i), fwd_a_sel, vecs[i].e_fa);
      chk($sformatf("vec%0d_fwd_b_sel", i), fwd_b_sel, vecs[i].e_fb);
      chk($sformatf("vec%0d_halted", i), halted, vecs[i].e_halted);
      @(posedge clk); #1;
    end
    chk("table_stall_cycles", stall_cycles, PERF ? 2 : 0);
    chk("table_flush_count", flush_count, PERF ? 1 : 0);
    chk("table_freeze_cycles", freeze_cycles, PERF ? 6 : 0);

    // Reset clears a sticky halt.
    rst_b = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_pc_en", pc_en, 1);
    chk("halt_reset_if_id_en", if_id_en, 1);
    chk("halt_reset_freeze_cycles", freeze_cycles, 0);
    @(posedge clk); #1;

    // Reset in the middle of a drain returns to normal running.
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_pc_en", pc_en, 0);
    chk("drain_if_id_flush", if_id_flush, 1);
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_drain_reset%0d_pc_en", i), pc_en, 1);
      chk($sformatf("post_drain_reset%0d_flush", i), if_id_flush, 0);
      chk($sformatf("post_drain_reset%0d_halted", i), halted, 0);
      @(posedge clk); #1;
    end

    // Randomized run against the model.
    do_reset();
    m_reset();
    halted_run = 0;
    for (int n = 0; n < 4000; n++) begin
      halted_run = (m_mode == 2) ? halted_run + 1 : 0;
      rst_b = !((halted_run > 3) || ($urandom_range(0, 299) == 0));
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
      @(negedge clk);
      if (rst_b) m_check();
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
